// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS data-memory arbiter.
// Holds the FSM states, the master IDs and the default sizing.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int LAT_DEF    = 2;
  localparam int MASK_W     = 8;
  localparam int CNT_W      = 4;   // holds LAT-1 for LAT up to 15

  localparam logic MST_IF = 1'b0;
  localparam logic MST_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie, the master that was not served last wins.
// Purely combinational; the grant is one-hot (bit 0 = IF, bit 1 = LS) or zero.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       if_valid_i,
  input  logic       ls_valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (if_valid_i && ls_valid_i) begin
      if (rr_ptr_i == MST_IF) gnt_o = 2'b10;
      else                    gnt_o = 2'b01;
    end else if (if_valid_i) begin
      gnt_o = 2'b01;
    end else if (ls_valid_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between instruction fetch (read-only) and load/store,
// one transaction at a time, with a programmable access latency LAT (1..15).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_we,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [MASK_W-1:0] ls_req_wmask,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mst_q, mst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  logic              resp_fire;

  mem_arb_rr u_rr (
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_o      (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= MST_IF;
      cnt_q    <= '0;
      mst_q    <= MST_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      mst_q    <= mst_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    mst_d         = mst_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_resp_data  = '0;
    ls_resp_data  = '0;
    mem_addr      = '0;
    mem_ce        = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    resp_fire     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gate the combinational grant so nothing is accepted while reset is held.
        if_req_ready = gnt[0] & rst_n;
        ls_req_ready = gnt[1] & rst_n;
        if (ls_req_valid && ls_req_ready) begin
          mst_d   = MST_LS;
          addr_d  = ls_req_addr;
          we_d    = ls_req_we;
          wdata_d = ls_req_wdata;
          wmask_d = ls_req_wmask;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = BUSY;
        end else if (if_req_valid && if_req_ready) begin
          mst_d   = MST_IF;
          addr_d  = if_req_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_ce    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
        // The write strobe fires only at the sample point, so it is issued once.
        mem_we    = (cnt_q == '0) && we_q;
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (mst_q == MST_LS) begin
          ls_resp_valid = 1'b1;
          ls_resp_data  = rdata_q;
          resp_fire     = ls_resp_ready;
        end else begin
          if_resp_valid = 1'b1;
          if_resp_data  = rdata_q;
          resp_fire     = if_resp_ready;
        end
        if (resp_fire) begin
          rr_ptr_d = mst_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with LAT = 1, 2, 3 share one memory model.
// Instance k has LAT = k+1; memory word index is addr[10:3].
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req_valid [3];
  logic        if_req_ready [3];
  logic [63:0] if_req_addr  [3];
  logic        if_resp_valid[3];
  logic        if_resp_ready[3];
  logic [63:0] if_resp_data [3];
  logic        ls_req_valid [3];
  logic        ls_req_ready [3];
  logic [63:0] ls_req_addr  [3];
  logic        ls_req_we    [3];
  logic [63:0] ls_req_wdata [3];
  logic [7:0]  ls_req_wmask [3];
  logic        ls_resp_valid[3];
  logic        ls_resp_ready[3];
  logic [63:0] ls_resp_data [3];
  logic [63:0] mem_addr     [3];
  logic        mem_ce       [3];
  logic        mem_we       [3];
  logic [63:0] mem_wdata    [3];
  logic [7:0]  mem_wmask    [3];
  logic [63:0] mem_rdata    [3];

  logic [63:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [63:0] pl_data;
  int          ce_cnt [3] = '{0, 0, 0};
  int          we_cnt [3] = '{0, 0, 0};

  int total = 0;
  int bad   = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(gi + 1)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid[gi]),
        .if_req_ready  (if_req_ready[gi]),
        .if_req_addr   (if_req_addr[gi]),
        .if_resp_valid (if_resp_valid[gi]),
        .if_resp_ready (if_resp_ready[gi]),
        .if_resp_data  (if_resp_data[gi]),
        .ls_req_valid  (ls_req_valid[gi]),
        .ls_req_ready  (ls_req_ready[gi]),
        .ls_req_addr   (ls_req_addr[gi]),
        .ls_req_we     (ls_req_we[gi]),
        .ls_req_wdata  (ls_req_wdata[gi]),
        .ls_req_wmask  (ls_req_wmask[gi]),
        .ls_resp_valid (ls_resp_valid[gi]),
        .ls_resp_ready (ls_resp_ready[gi]),
        .ls_resp_data  (ls_resp_data[gi]),
        .mem_addr      (mem_addr[gi]),
        .mem_ce        (mem_ce[gi]),
        .mem_we        (mem_we[gi]),
        .mem_wdata     (mem_wdata[gi]),
        .mem_wmask     (mem_wmask[gi]),
        .mem_rdata     (mem_rdata[gi])
      );
      assign mem_rdata[gi] = mem[mem_addr[gi][10:3]];
    end
  endgenerate

  // Memory model: preload port plus byte-masked writes from every instance.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    for (int k = 0; k < 3; k++) begin
      if (mem_ce[k]) ce_cnt[k] <= ce_cnt[k] + 1;
      if (mem_we[k]) begin
        we_cnt[k] <= we_cnt[k] + 1;
        for (int b = 0; b < 8; b++)
          if (mem_wmask[k][b]) mem[mem_addr[k][10:3]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end in the low clock phase, just after a negedge.
  task automatic preload(input logic [7:0] idx, input logic [63:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_resp(input int k, input bit ls, output int n);
    n = 1;
    while (!(ls ? ls_resp_valid[k] : if_resp_valid[k]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(ls ? ls_resp_valid[k] : if_resp_valid[k])) n = -1;
  endtask

  task automatic consume(input int k, input bit ls);
    if (ls) ls_resp_ready[k] = 1'b1; else if_resp_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    if (ls) ls_resp_ready[k] = 1'b0; else if_resp_ready[k] = 1'b0;
  endtask

  task automatic txn(input int k, input bit ls, input bit we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     output logic [63:0] rdata, output int lat);
    if (ls) begin
      ls_req_valid[k] = 1'b1; ls_req_addr[k] = addr; ls_req_we[k] = we;
      ls_req_wdata[k] = wdata; ls_req_wmask[k] = wmask;
    end else begin
      if_req_valid[k] = 1'b1; if_req_addr[k] = addr;
    end
    #1;
    if (ls) chk("ls_req_ready", {63'd0, ls_req_ready[k]}, 64'd1);
    else    chk("if_req_ready", {63'd0, if_req_ready[k]}, 64'd1);
    @(posedge clk); @(negedge clk);
    if (ls) ls_req_valid[k] = 1'b0; else if_req_valid[k] = 1'b0;
    wait_resp(k, ls, lat);
    rdata = ls ? ls_resp_data[k] : if_resp_data[k];
    consume(k, ls);
    $display("txn inst=%0d %s we=%0d addr=%h data=%h lat=%0d", k, ls ? "LS" : "IF", we, addr, rdata, lat);
  endtask

  logic [63:0] rd;
  int          lat, ce0, we0, n, hs, nr, any_resp;
  int          resp_cyc [2];
  logic [63:0] resp_dat [2];

  initial begin
    for (int k = 0; k < 3; k++) begin
      if_req_valid[k] = 0; if_req_addr[k] = 0; if_resp_ready[k] = 0;
      ls_req_valid[k] = 0; ls_req_addr[k] = 0; ls_req_we[k] = 0;
      ls_req_wdata[k] = 0; ls_req_wmask[k] = 0; ls_resp_ready[k] = 0;
    end
    pl_en = 0; pl_idx = 0; pl_data = 0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset state: nothing granted or driven even with requests pending.
    if_req_valid[1] = 1'b1; ls_req_valid[1] = 1'b1;
    #1;
    chk("rst_if_ready",  {63'd0, if_req_ready[1]},  64'd0);
    chk("rst_ls_ready",  {63'd0, ls_req_ready[1]},  64'd0);
    chk("rst_mem_ce",    {63'd0, mem_ce[1]},        64'd0);
    chk("rst_resp_v",    {63'd0, ls_resp_valid[1]}, 64'd0);
    chk("rst_mem_addr",  mem_addr[1],               64'd0);
    if_req_valid[1] = 1'b0; ls_req_valid[1] = 1'b0;
    preload(8'd0, 64'h0000_0000_DEAD_BEEF);
    preload(8'd4, 64'h0000_0000_0BAD_F00D);
    rst_n = 1'b1;

    // Ties right after reset: LS, IF, LS.
    for (int i = 0; i < 3; i++) begin
      bit ls_win;
      ls_win = (i % 2 == 0);
      if_req_valid[1] = 1'b1; if_req_addr[1] = 64'h0;
      ls_req_valid[1] = 1'b1; ls_req_addr[1] = 64'h8; ls_req_we[1] = 1'b0;
      #1;
      chk($sformatf("tie%0d_ls_ready", i), {63'd0, ls_req_ready[1]}, {63'd0, ls_win});
      chk($sformatf("tie%0d_if_ready", i), {63'd0, if_req_ready[1]}, {63'd0, !ls_win});
      @(posedge clk); @(negedge clk);
      if (ls_win) ls_req_valid[1] = 1'b0; else if_req_valid[1] = 1'b0;
      wait_resp(1, ls_win, lat);
      chk($sformatf("tie%0d_lat", i), 64'(lat), 64'd3);
      consume(1, ls_win);
      $display("txn inst=1 tie%0d winner=%s lat=%0d", i, ls_win ? "LS" : "IF", lat);
    end
    if_req_valid[1] = 1'b0; ls_req_valid[1] = 1'b0;

    // IF read, LAT = 2.
    ce0 = ce_cnt[1]; we0 = we_cnt[1];
    txn(1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, lat);
    chk("if_rd_lat",  64'(lat), 64'd3);
    chk("if_rd_data", rd, 64'h0000_0000_DEAD_BEEF);
    chk("if_rd_ce",   64'(ce_cnt[1] - ce0), 64'd2);
    chk("if_rd_we",   64'(we_cnt[1] - we0), 64'd0);

    // LS write, read back, partial-mask write, read back.
    we0 = we_cnt[1];
    txn(1, 1'b1, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, lat);
    chk("ls_wr_ack",  rd, 64'd0);
    chk("ls_wr_lat",  64'(lat), 64'd3);
    chk("ls_wr_we",   64'(we_cnt[1] - we0), 64'd1);
    we0 = we_cnt[1];
    txn(1, 1'b1, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, lat);
    chk("ls_rd_data", rd, 64'h1122_3344_5566_7788);
    chk("ls_rd_we",   64'(we_cnt[1] - we0), 64'd0);
    txn(1, 1'b1, 1'b1, 64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, rd, lat);
    txn(1, 1'b1, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, lat);
    chk("ls_mask_data", rd, 64'h1122_3344_CCCC_DDDD);

    // Response hold with IF waiting behind it.
    ls_req_valid[1] = 1'b1; ls_req_addr[1] = 64'h8000_0010; ls_req_we[1] = 1'b0;
    #1;
    chk("hold_ls_ready", {63'd0, ls_req_ready[1]}, 64'd1);
    @(posedge clk); @(negedge clk);
    ls_req_valid[1] = 1'b0;
    if_req_valid[1] = 1'b1; if_req_addr[1] = 64'h8000_0000;
    wait_resp(1, 1'b1, lat);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("hold%0d_valid", j),    {63'd0, ls_resp_valid[1]}, 64'd1);
      chk($sformatf("hold%0d_data", j),     ls_resp_data[1], 64'h1122_3344_CCCC_DDDD);
      chk($sformatf("hold%0d_if_ready", j), {63'd0, if_req_ready[1]}, 64'd0);
      @(negedge clk);
    end
    consume(1, 1'b1);
    #1;
    chk("after_hold_if_ready", {63'd0, if_req_ready[1]}, 64'd1);
    @(posedge clk); @(negedge clk);
    if_req_valid[1] = 1'b0;
    wait_resp(1, 1'b0, lat);
    chk("after_hold_if_data", if_resp_data[1], 64'h0000_0000_DEAD_BEEF);
    consume(1, 1'b0);
    $display("txn inst=1 hold LS then IF lat=%0d", lat);

    // Reset during BUSY of a write, LAT = 3.
    we0 = we_cnt[2];
    ls_req_valid[2] = 1'b1; ls_req_addr[2] = 64'h8000_0020; ls_req_we[2] = 1'b1;
    ls_req_wdata[2] = 64'h5555_5555_5555_5555; ls_req_wmask[2] = 8'hFF;
    #1;
    chk("rb_ls_ready", {63'd0, ls_req_ready[2]}, 64'd1);
    @(posedge clk); @(negedge clk);
    ls_req_valid[2] = 1'b0;
    chk("rb_busy_ce", {63'd0, mem_ce[2]}, 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_ce_drop", {63'd0, mem_ce[2]}, 64'd0);
    chk("rb_we_drop", {63'd0, mem_we[2]}, 64'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    any_resp = 0;
    for (int j = 0; j < 5; j++) begin
      if (ls_resp_valid[2]) any_resp = 1;
      @(negedge clk);
    end
    chk("rb_no_resp", 64'(any_resp), 64'd0);
    chk("rb_no_write", 64'(we_cnt[2] - we0), 64'd0);
    txn(2, 1'b1, 1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, lat);
    chk("rb_after_data", rd, 64'h0000_0000_0BAD_F00D);
    chk("rb_after_lat",  64'(lat), 64'd4);

    // LAT = 1 back-to-back IF reads with resp_ready tied high.
    preload(8'd0, 64'h0123_4567_89AB_CDEF);
    preload(8'd1, 64'hFEDC_BA98_7654_3210);
    if_resp_ready[0] = 1'b1;
    hs = 0; nr = 0;
    for (int c = 0; c < 12; c++) begin
      if_req_valid[0] = (hs < 2);
      if_req_addr[0]  = (hs == 0) ? 64'h0 : 64'h8;
      #1;
      if (if_resp_valid[0] && nr < 2) begin
        resp_cyc[nr] = c; resp_dat[nr] = if_resp_data[0]; nr++;
      end
      if (if_req_ready[0] && if_req_valid[0]) hs++;
      @(negedge clk);
    end
    if_req_valid[0] = 1'b0; if_resp_ready[0] = 1'b0;
    chk("b2b_count", 64'(nr), 64'd2);
    chk("b2b_first_cyc", 64'(resp_cyc[0]), 64'd2);
    chk("b2b_spacing", 64'(resp_cyc[1] - resp_cyc[0]), 64'd3);
    chk("b2b_data0", resp_dat[0], 64'h0123_4567_89AB_CDEF);
    chk("b2b_data1", resp_dat[1], 64'hFEDC_BA98_7654_3210);
    $display("txn inst=0 b2b responses=%0d at cycles %0d,%0d", nr, resp_cyc[0], resp_cyc[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DPI-backed data memory port between instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Valid/ready request and response handshakes on each side; one transaction in flight at a time.
- Programmable access latency models a non-zero-latency memory.
- Drives the memory's addr/ce/we/wdata/wmask pins so each write is issued exactly once.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- LAT, 2, cycles from grant to memory sample point; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  ADDR_W  IF read address.
- if_resp_valid  out  1  IF read data available.
- if_resp_ready  in  1  IF consumes response.
- if_resp_data  out  DATA_W  IF read data.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_req_addr  in  ADDR_W  LS address.
- ls_req_we  in  1  1 = write, 0 = read.
- ls_req_wdata  in  DATA_W  LS write data.
- ls_req_wmask  in  8  LS byte-write mask.
- ls_resp_valid  out  1  LS response (read data or write ack).
- ls_resp_ready  in  1  LS consumes response.
- ls_resp_data  out  DATA_W  LS read data; 0 for write ack.
- mem_addr  out  ADDR_W  to memory addr.
- mem_ce  out  1  to memory chip enable.
- mem_we  out  1  to memory write enable.
- mem_wdata  out  DATA_W  to memory write data.
- mem_wmask  out  8  to memory write mask.
- mem_rdata  in  DATA_W  from memory read data (combinational).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, rr_ptr = IF (so LS wins the first tie), counter 0, latched request 0.
  - All outputs are 0 during and after reset, including all req_ready, resp_valid, resp_data and mem_* outputs.
- State IDLE:
  - Grant is combinational. If only one requester is valid, it gets ready = 1.
  - If both are valid, the requester other than rr_ptr wins. At most one req_ready is high.
  - On handshake (valid & ready), latch the master ID, addr, we, wdata and wmask; set cnt = LAT-1; go to BUSY.
- State BUSY:
  - mem_ce = 1; mem_addr, mem_wdata and mem_wmask come from the latched request.
  - mem_we = 1 only when cnt == 0 and the latched we is 1, so the write is issued for exactly one cycle.
  - cnt decrements each cycle. At cnt == 0, register mem_rdata (or 0 for a write) into the response data register and go to RESP.
  - With LAT = 1, BUSY lasts one cycle.
- State RESP:
  - Assert resp_valid for the latched master only; resp_data is held stable.
  - Once resp_valid is asserted, it stays high until resp_ready is sampled high.
  - On resp_valid & resp_ready: set rr_ptr = served master, go to IDLE. The next grant is possible in the following cycle, with no bypass.
- Outside BUSY: mem_ce = mem_we = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0.
- Both req_ready are 0 in BUSY and RESP. A requester holding valid waits, and its request is not lost.
- Request fields only need to be stable in the handshake cycle.
- Request-to-response latency: handshake at cycle t gives resp_valid at cycle t+LAT+1.
- Reset mid-operation: state returns to IDLE immediately and asynchronously. mem_we and mem_ce drop with no further write, and the pending response is discarded.
- An IF request never writes: the latched we is forced to 0 and wmask to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - master ID constants (MST_IF = 0, MST_LS = 1);
  - the default width and latency constants.
- One sub-module, mem_arb_rr: a 2-way round-robin picker.
  - Inputs: two valids and rr_ptr.
  - Output: a one-hot grant.
  - Purely combinational.

Test Plan:
- IF read, LAT = 2, mem returns 64'hDEAD_BEEF at 0x8000_0000 → if_req_ready in the handshake cycle, mem_ce high 2 cycles, if_resp_valid 3 cycles after the handshake with data DEAD_BEEF; mem_we never asserted.
- LS write of 64'h1122_3344_5566_7788, wmask 8'hFF, to 0x8000_0010, then an LS read of the same address → mem_we high exactly 1 cycle, ack data 0, read returns 1122_3344_5566_7788.
- IF and LS both valid right after reset → LS granted first. After LS completes with IF still valid, IF is granted. Repeated ties alternate LS, IF, LS.
- Response hold: ls_resp_ready held low for 3 cycles → ls_resp_valid stays high, data stable; if_req_ready stays 0 throughout.
- rst_n pulsed low during BUSY of a write with LAT = 3 → mem_we/mem_ce go 0 immediately, no response is issued, and the next request after release completes normally.
- LAT = 1 back-to-back IF reads at 0x0, 0x8 with resp_ready tied high → one response every 3 cycles, data in order.
